seq_det_scheduler: RTL and testbench
====================================

Name: seq_det_scheduler

Overview:
- Shares one "110"-class serial pattern-match engine across NUM_CH independent serial bit channels.
- Round-robin arbitration admits one bit per cycle.
- Keeps per-channel shift history and a per-channel saturating match counter.
- A run-control FSM stops all intake after a programmable total match count.
- Sits between the serial sources and the system's event and status logic.

Parameters:
NUM_CH, 4, number of serial channels (>=2)
PAT_LEN, 3, pattern length in bits (>=2)
PATTERN, 3'b110, PAT_LEN-bit target; the newest bit is the LSB
CNT_W, 8, width of the match counters and match_limit
CH_W, $clog2(NUM_CH), channel index width (derived)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
enable  in  1  run request
clear_cnt  in  1  synchronous clear of histories and counters; leaves DONE
match_limit  in  CNT_W  total matches before stop; 0 = unlimited
ch_valid  in  NUM_CH  per-channel bit valid
ch_bit  in  NUM_CH  per-channel serial bit
ch_ready  out  NUM_CH  per-channel accept (one-hot or zero)
det_valid  out  1  one-cycle match pulse
det_ch  out  CH_W  channel of the match; held until the next match
done  out  1  high while in DONE
cnt_sel  in  CH_W  readback channel select
cnt_out  out  CNT_W  match counter of cnt_sel (combinational)

Behaviour:
- Reset: clocking is rising-edge clk only; rst is asynchronous, active-low.
- Reset values: state=IDLE, ch_ready=0, det_valid=0, det_ch=0, done=0, all histories/fill/counters=0, total=0, rr_ptr=NUM_CH-1 (channel 0 wins first).
- FSM states: IDLE, RUN, DONE.
  - IDLE->RUN when enable=1.
  - RUN->IDLE when enable=0; histories are kept.
  - RUN->DONE on the edge where total reaches match_limit (match_limit!=0).
  - DONE->IDLE on clear_cnt=1.
  - enable has no effect in DONE.
- Arbitration: in RUN with clear_cnt=0, grant the first channel with ch_valid=1, searching from rr_ptr+1 with wrap.
  - ch_ready = grant one-hot; may depend combinationally on ch_valid.
  - Transfer occurs when ch_valid[i] & ch_ready[i].
  - rr_ptr is updated to i only on a transfer.
  - No valid inputs: ch_ready=0 and rr_ptr is unchanged.
- History update on a transfer (channel i only): hist_i <= {hist_i[PAT_LEN-2:0], ch_bit[i]}; fill_i increments, saturating at PAT_LEN.
- Match: the new history equals PATTERN and the new fill equals PAT_LEN.
  - det_valid=1 for exactly the cycle after the accepting edge (latency 1).
  - det_ch=i.
  - cnt_i and total each increment, saturating at all-ones (no wrap).
- Channels are fully independent; another channel's bits never touch hist_i.
- clear_cnt has priority over everything else that cycle:
  - ch_ready=0, det_valid=0 next cycle.
  - All hist/fill/cnt/total=0.
  - DONE->IDLE.
  - rr_ptr unchanged.
- In IDLE and DONE, ch_ready=0; no history change.
- match_limit is sampled every cycle. If it is lowered below total while in RUN, DONE is entered on the next match.
- Reset mid-stream discards partial histories; no stale detection after release.
- cnt_out is a combinational mux of cnt[cnt_sel]. Out-of-range cnt_sel returns 0.

Optional Feature:
- Macro: SEQ_SCHED_OVERLAP_EN.
- Defined: overlapping detection; history and fill are kept after a match.
- Undefined: non-overlapping detection; on a match, hist_i and fill_i clear to 0, so the next match needs PAT_LEN fresh bits.

Test Plan:
1. NUM_CH=4, PATTERN=110, enable=1, ch0 only sends 1,1,0 -> det_valid pulses once, 1 cycle after the third transfer; det_ch=0; cnt_out(sel=0)=1; other counters 0.
2. All four ch_valid held high for 8 cycles -> ch_ready one-hot sequence 0,1,2,3,0,1,2,3; each channel gets exactly 2 transfers.
3. Interleave ch1:1, ch2:1, ch1:1, ch2:0, ch1:0 -> exactly one det_valid, det_ch=1; cnt[2]=0.
4. PATTERN=101, ch0 sends 1,0,1,0,1 -> with SEQ_SCHED_OVERLAP_EN: 2 pulses, cnt[0]=2; without it: 1 pulse, cnt[0]=1.
5. match_limit=2, two matches on ch3 -> done=1, state DONE, ch_ready=0 despite ch_valid=1; clear_cnt pulse -> done=0, all counters 0; with enable=1, intake resumes one cycle after IDLE.
6. ch0 sends 1,1; assert rst low mid-cycle (asynchronous), release; ch0 sends 0 -> no det_valid; cnt[0]=0; first grant goes to ch0.

Source files
------------

// File: rtl/seq_det_scheduler_if.sv
// Purpose: channel-side and status-side signal bundle for seq_det_scheduler.
// Latency: none (wires only); the master drives the serial channels and controls,
// and the slave returns the per-channel accepts, the detect pulse and the counter readback.
interface seq_det_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int CH_W   = $clog2(NUM_CH)
);
  logic              enable;
  logic              clear_cnt;
  logic [CNT_W-1:0]  match_limit;
  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH-1:0] ch_bit;
  logic [NUM_CH-1:0] ch_ready;
  logic              det_valid;
  logic [CH_W-1:0]   det_ch;
  logic              done;
  logic [CH_W-1:0]   cnt_sel;
  logic [CNT_W-1:0]  cnt_out;

  // Source / controller side
  modport master (
    output enable, clear_cnt, match_limit, ch_valid, ch_bit, cnt_sel,
    input  ch_ready, det_valid, det_ch, done, cnt_out
  );

  // Scheduler side
  modport slave (
    input  enable, clear_cnt, match_limit, ch_valid, ch_bit, cnt_sel,
    output ch_ready, det_valid, det_ch, done, cnt_out
  );
endinterface

// File: rtl/seq_det_scheduler.sv
// Purpose: one shared PATTERN matcher time-sliced round-robin over NUM_CH serial bit channels,
// Latency: 1 cycle from the accepting edge to det_valid; cnt_out is a combinational readback,
// Backpressure: at most one ch_ready per cycle (valid/ready); no intake in IDLE/DONE or while clear_cnt=1.
// Ports: clk, rst (async active-low), bus (seq_det_scheduler_if.slave: channel bits, controls, detect, status).
// Build option: SEQ_SCHED_OVERLAP_EN keeps history after a match (overlapping detection);
// undefined, a match wipes that channel's history so the next match needs PAT_LEN fresh bits.
module seq_det_scheduler #(
  parameter int                 NUM_CH  = 4,
  parameter int                 PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = 3'b110,
  parameter int                 CNT_W   = 8,
  parameter int                 CH_W    = $clog2(NUM_CH)
) (
  input logic                 clk,
  input logic                 rst,
  seq_det_scheduler_if.slave  bus
);

  localparam int FW = $clog2(PAT_LEN + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e             state_q, state_d;
  logic [CH_W-1:0]    rr_ptr_q;
  logic [PAT_LEN-1:0] hist_q [NUM_CH];
  logic [FW-1:0]      fill_q [NUM_CH];
  logic [CNT_W-1:0]   cnt_q  [NUM_CH];
  logic [CNT_W-1:0]   total_q;
  logic               det_valid_q;
  logic [CH_W-1:0]    det_ch_q;

  logic               intake_en;
  logic               grant_vld;
  logic [CH_W-1:0]    grant_idx;
  logic [NUM_CH-1:0]  grant_oh;
  logic [PAT_LEN-1:0] hist_new;
  logic [FW-1:0]      fill_new;
  logic               match;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   total_inc;
  logic               limit_hit;

  // clear_cnt blocks intake in the same cycle it is seen
  assign intake_en = (state_q == ST_RUN) && !bus.clear_cnt;

  // Round-robin: first valid channel after the last one served, wrapping
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    if (intake_en) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        idx = (int'(rr_ptr_q) + k) % NUM_CH;
        if (!grant_vld && bus.ch_valid[idx]) begin
          grant_vld     = 1'b1;
          grant_idx     = CH_W'(idx);
          grant_oh[idx] = 1'b1;
        end
      end
    end
  end

  assign bus.ch_ready = grant_oh;

  // Shared match engine operating on the granted channel's history
  always_comb begin
    hist_new  = {hist_q[grant_idx][PAT_LEN-2:0], bus.ch_bit[grant_idx]};
    fill_new  = (fill_q[grant_idx] == FW'(PAT_LEN)) ? fill_q[grant_idx]
                                                    : fill_q[grant_idx] + 1'b1;
    match     = grant_vld && (hist_new == PATTERN) && (fill_new == FW'(PAT_LEN));
    cnt_inc   = (&cnt_q[grant_idx]) ? cnt_q[grant_idx] : cnt_q[grant_idx] + 1'b1;
    total_inc = (&total_q) ? total_q : total_q + 1'b1;
    // >= so that a limit lowered below the running total stops on the next match
    limit_hit = match && (bus.match_limit != '0) && (total_inc >= bus.match_limit);
  end

  // Run-control FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.enable) state_d = ST_RUN;
      ST_RUN: begin
        if (limit_hit)        state_d = ST_DONE;
        else if (!bus.enable) state_d = ST_IDLE;
      end
      ST_DONE: if (bus.clear_cnt) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= CH_W'(NUM_CH - 1);
      total_q     <= '0;
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        hist_q[i] <= '0;
        fill_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      det_valid_q <= match;
      if (match)     det_ch_q <= grant_idx;
      if (grant_vld) rr_ptr_q <= grant_idx;
      if (bus.clear_cnt) begin
        total_q <= '0;
        for (int i = 0; i < NUM_CH; i++) begin
          hist_q[i] <= '0;
          fill_q[i] <= '0;
          cnt_q[i]  <= '0;
        end
      end else if (grant_vld) begin
        if (match) begin
          cnt_q[grant_idx] <= cnt_inc;
          total_q          <= total_inc;
        end
`ifdef SEQ_SCHED_OVERLAP_EN
        hist_q[grant_idx] <= hist_new;
        fill_q[grant_idx] <= fill_new;
`else
        if (match) begin
          hist_q[grant_idx] <= '0;
          fill_q[grant_idx] <= '0;
        end else begin
          hist_q[grant_idx] <= hist_new;
          fill_q[grant_idx] <= fill_new;
        end
`endif
      end
    end
  end

  assign bus.det_valid = det_valid_q;
  assign bus.det_ch    = det_ch_q;
  assign bus.done      = (state_q == ST_DONE);

  // Counter readback; selects beyond NUM_CH-1 read as zero
  always_comb begin
    bus.cnt_out = '0;
    if (int'(bus.cnt_sel) < NUM_CH) bus.cnt_out = cnt_q[bus.cnt_sel];
  end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Purpose: self-checking bench for seq_det_scheduler (directed table, corner sequences, random vs model).
// Latency: model expects det_valid one cycle after the accepting edge.
// Backpressure: ch_ready is compared every cycle against the model's grant.
module tb_seq_det_scheduler;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_det_scheduler_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();
  seq_det_scheduler_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus101 ();

  seq_det_scheduler #(.NUM_CH(NUM_CH), .PAT_LEN(3), .PATTERN(3'b110), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  seq_det_scheduler #(.NUM_CH(NUM_CH), .PAT_LEN(3), .PATTERN(3'b101), .CNT_W(CNT_W)) dut101 (
    .clk(clk), .rst(rst), .bus(bus101));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam bit [2:0] M_PAT = 3'b110;
  int m_state, m_rr, m_total, m_det, m_detch;
  int m_cnt [NUM_CH];
  int mq [NUM_CH][$];   // bits received per channel, oldest first

  task automatic m_reset();
    m_state = S_IDLE; m_rr = NUM_CH - 1; m_total = 0; m_det = 0; m_detch = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_cnt[c] = 0;
      mq[c].delete();
    end
  endtask

  function automatic int m_grant(input logic [3:0] v, input logic clr);
    if (m_state != S_RUN || clr) return -1;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (v[(m_rr + k) % NUM_CH]) return (m_rr + k) % NUM_CH;
    end
    return -1;
  endfunction

  task automatic m_step(input logic en, input logic clr, input logic [7:0] lim,
                        input logic [3:0] v, input logic [3:0] b);
    int g;
    bit hit;
    g = m_grant(v, clr);
    m_det = 0;
    hit = 0;
    if (clr) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mq[c].delete();
        m_cnt[c] = 0;
      end
      m_total = 0;
      if (m_state == S_DONE) m_state = S_IDLE;
      else if (m_state == S_IDLE && en) m_state = S_RUN;
      else if (m_state == S_RUN && !en) m_state = S_IDLE;
      return;
    end
    if (g >= 0) begin
      m_rr = g;
      mq[g].push_back(int'(b[g]));
      if (mq[g].size() > 3) void'(mq[g].pop_front());
      if (mq[g].size() == 3)
        hit = (mq[g][0] == int'(M_PAT[2])) && (mq[g][1] == int'(M_PAT[1])) &&
              (mq[g][2] == int'(M_PAT[0]));
      if (hit) begin
        m_det = 1;
        m_detch = g;
        m_cnt[g] = (m_cnt[g] < 255) ? m_cnt[g] + 1 : 255;
        m_total = (m_total < 255) ? m_total + 1 : 255;
`ifndef SEQ_SCHED_OVERLAP_EN
        mq[g].delete();
`endif
      end
    end
    case (m_state)
      S_IDLE: if (en) m_state = S_RUN;
      S_RUN: begin
        if (hit && lim != 0 && m_total >= int'(lim)) m_state = S_DONE;
        else if (!en) m_state = S_IDLE;
      end
      default: ;
    endcase
  endtask

  // ---------------- cycle driver ----------------
  logic [3:0] got_ready;
  logic       got_det, got_done;
  logic [1:0] got_detch;
  logic [7:0] got_cnt;

  // Called just after a rising edge; returns just after the next one.
  task automatic run_cycle(input logic en, input logic clr, input logic [7:0] lim,
                           input logic [3:0] v, input logic [3:0] b, input logic [1:0] sel);
    int g;
    bus.enable = en; bus.clear_cnt = clr; bus.match_limit = lim;
    bus.ch_valid = v; bus.ch_bit = b; bus.cnt_sel = sel;
    #1;
    got_ready = bus.ch_ready;
    g = m_grant(v, clr);
    chk("model_ready", got_ready, (g < 0) ? 0 : (1 << g));
    @(posedge clk);
    m_step(en, clr, lim, v, b);
    #1;
    got_det = bus.det_valid; got_detch = bus.det_ch;
    got_done = bus.done; got_cnt = bus.cnt_out;
    chk("model_det_valid", got_det, m_det);
    if (m_det != 0) chk("model_det_ch", got_detch, m_detch);
    chk("model_done", got_done, (m_state == S_DONE) ? 1 : 0);
    chk("model_cnt_out", got_cnt, m_cnt[sel]);
  endtask

  typedef struct {
    logic       en;
    logic [3:0] v;
    logic [3:0] b;
    logic [1:0] sel;
    logic [3:0] ready;
    logic       det;
    logic [1:0] detch;
    logic [7:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic [3:0] v, input logic [3:0] b,
                              input logic [1:0] sel, input logic [3:0] ready,
                              input logic det, input logic [1:0] detch, input logic [7:0] cnt);
    vec_t r;
    r.en = en; r.v = v; r.b = b; r.sel = sel; r.ready = ready;
    r.det = det; r.detch = detch; r.cnt = cnt;
    return r;
  endfunction

  initial begin
    vec_t tbl[$];
    int pulses;
    logic [3:0] rv, rb;
    logic [7:0] lim;
    logic en, clr;
    logic [4:0] seq101;
    logic [5:0] seq3;

    // Reset and reset values
    rst = 1'b0;
    bus.enable = 0; bus.clear_cnt = 0; bus.match_limit = 0;
    bus.ch_valid = 0; bus.ch_bit = 0; bus.cnt_sel = 0;
    bus101.enable = 0; bus101.clear_cnt = 0; bus101.match_limit = 0;
    bus101.ch_valid = 0; bus101.ch_bit = 0; bus101.cnt_sel = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready", bus.ch_ready, 0);
    chk("rst_det_valid", bus.det_valid, 0);
    chk("rst_det_ch", bus.det_ch, 0);
    chk("rst_done", bus.done, 0);
    for (int s = 0; s < NUM_CH; s++) begin
      bus.cnt_sel = 2'(s);
      #1;
      chk("rst_cnt_out", bus.cnt_out, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: IDLE->RUN, full round-robin, single-channel 110, interleaved 110
    tbl.push_back(mk(1, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 4'hF, 4'h0, 0, 4'(1 << (i % 4)), 0, 0, 0));
    tbl.push_back(mk(1, 4'h1, 4'h1, 0, 4'h1, 0, 0, 0));
    tbl.push_back(mk(1, 4'h1, 4'h1, 0, 4'h1, 0, 0, 0));
    tbl.push_back(mk(1, 4'h1, 4'h0, 0, 4'h1, 1, 0, 1));
    tbl.push_back(mk(1, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h2, 4'h2, 1, 4'h2, 0, 0, 0));
    tbl.push_back(mk(1, 4'h4, 4'h4, 1, 4'h4, 0, 0, 0));
    tbl.push_back(mk(1, 4'h2, 4'h2, 1, 4'h2, 0, 0, 0));
    tbl.push_back(mk(1, 4'h4, 4'h0, 1, 4'h4, 0, 0, 0));
    tbl.push_back(mk(1, 4'h2, 4'h0, 1, 4'h2, 1, 1, 1));
    tbl.push_back(mk(1, 4'h0, 4'h0, 2, 4'h0, 0, 1, 0));
    foreach (tbl[i]) begin
      run_cycle(tbl[i].en, 0, 0, tbl[i].v, tbl[i].b, tbl[i].sel);
      chk($sformatf("tbl%0d_ready", i), got_ready, tbl[i].ready);
      chk($sformatf("tbl%0d_det", i), got_det, tbl[i].det);
      chk($sformatf("tbl%0d_det_ch", i), got_detch, tbl[i].detch);
      chk($sformatf("tbl%0d_cnt", i), got_cnt, tbl[i].cnt);
    end

    // Pattern 101 on the second instance: overlap yields 2, non-overlap 1
    seq101 = 5'b10101;
    pulses = 0;
    bus101.enable = 1;
    run_cycle(1, 0, 0, 4'h0, 4'h0, 0);
    for (int i = 0; i < 6; i++) begin
      bus101.ch_valid = (i < 5) ? 4'h1 : 4'h0;
      bus101.ch_bit = (i < 5) ? {3'b000, seq101[4 - (i % 5)]} : 4'h0;
      run_cycle(1, 0, 0, 4'h0, 4'h0, 0);
      if (bus101.det_valid) pulses++;
    end
    bus101.cnt_sel = 0;
    #1;
`ifdef SEQ_SCHED_OVERLAP_EN
    chk("p101_pulses", pulses, 2);
    chk("p101_cnt0", bus101.cnt_out, 2);
`else
    chk("p101_pulses", pulses, 1);
    chk("p101_cnt0", bus101.cnt_out, 1);
`endif
    bus101.enable = 0;
    bus101.ch_valid = 0;

    // match_limit=2 stop, DONE hold, clear, resume
    run_cycle(1, 1, 0, 4'h0, 4'h0, 3);
    chk("lim_clear_done", got_done, 0);
    seq3 = 6'b110110;
    for (int i = 0; i < 6; i++)
      run_cycle(1, 0, 2, 4'h8, {seq3[5 - i], 3'b000}, 3);
    chk("lim_done", got_done, 1);
    chk("lim_det", got_det, 1);
    chk("lim_det_ch", got_detch, 3);
    run_cycle(1, 0, 2, 4'hF, 4'hF, 3);
    chk("done_ready", got_ready, 0);
    chk("done_hold", got_done, 1);
    chk("done_cnt3", got_cnt, 2);
    run_cycle(1, 1, 2, 4'hF, 4'h0, 3);
    chk("clr_ready", got_ready, 0);
    chk("clr_done", got_done, 0);
    chk("clr_cnt3", got_cnt, 0);
    run_cycle(1, 0, 0, 4'h8, 4'h0, 3);
    chk("idle_ready", got_ready, 0);
    run_cycle(1, 0, 0, 4'h8, 4'h0, 3);
    chk("resume_ready", got_ready, 4'h8);

    // Async reset mid-stream
    run_cycle(1, 0, 0, 4'h1, 4'h1, 0);
    run_cycle(1, 0, 0, 4'h1, 4'h1, 0);
    #2;
    rst = 1'b0;
    bus.enable = 0; bus.ch_valid = 0; bus.ch_bit = 0; bus.cnt_sel = 0;
    #1;
    chk("arst_ready", bus.ch_ready, 0);
    chk("arst_det", bus.det_valid, 0);
    chk("arst_cnt0", bus.cnt_out, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_cycle(1, 0, 0, 4'h0, 4'h0, 0);
    run_cycle(1, 0, 0, 4'hF, 4'h0, 0);
    chk("arst_first_grant", got_ready, 4'h1);
    chk("arst_no_det", got_det, 0);
    chk("arst_cnt0_after", got_cnt, 0);

    // Randomized traffic against the model
    lim = 0;
    for (int n = 0; n < 1500; n++) begin
      en  = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 39) == 0) lim = 8'($urandom_range(0, 12));
      rv = 4'($urandom);
      rb = 4'($urandom);
      run_cycle(en, clr, lim, rv, rb, 2'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
